// File: rtl/sfu_acc_drain.sv
`default_nettype none
// ============================================================================
// Module   : sfu_acc_drain
// Purpose  : Per-lane accumulator bank with a drain engine. Incoming psum
//            vectors are summed into a circular set of num_ch entries. On
//            send_out the bank is streamed out one entry per handshake. Each
//            value is saturated to psum_bw and optionally ReLU-clipped, and
//            each entry is cleared as it is consumed.
// Ports    : clk, reset              - clock, synchronous active-high reset
//            psum_in/in_valid/in_ready - input vector stream (col lanes)
//            num_ch                   - active entries (0 or > depth = depth)
//            relu_en                  - ReLU on drained values
//            send_out                 - drain request (honoured in ACC only)
//            out_data/out_valid/out_ready/out_idx - drained entry stream
//            busy                     - block not idle
//            err                      - sticky: input arrived during drain
// Revision : 1.0 - initial release
// ============================================================================
module sfu_acc_drain #(
    parameter int  psum_bw = 16,
    parameter int  acc_bw  = 20,
    parameter int  col     = 8,
    parameter int  depth   = 16,
    localparam int ch_bw   = $clog2(depth) + 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [psum_bw*col-1:0] psum_in,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [ch_bw-1:0]       num_ch,
    input  logic                   relu_en,
    input  logic                   send_out,
    output logic [psum_bw*col-1:0] out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ch_bw-1:0]       out_idx,
    output logic                   busy,
    output logic                   err
);

    localparam int               c_ptr_bw   = (depth > 1) ? $clog2(depth) : 1;
    localparam logic [1:0]       c_st_idle  = 2'd0;
    localparam logic [1:0]       c_st_acc   = 2'd1;
    localparam logic [1:0]       c_st_drain = 2'd2;
    localparam logic [ch_bw-1:0] c_depth    = ch_bw'(depth);
    // Signed psum_bw limits expressed at accumulator width.
    localparam logic signed [acc_bw-1:0] c_sat_hi =
        {{(acc_bw-psum_bw+1){1'b0}}, {(psum_bw-1){1'b1}}};
    localparam logic signed [acc_bw-1:0] c_sat_lo =
        {{(acc_bw-psum_bw+1){1'b1}}, {(psum_bw-1){1'b0}}};

    logic [1:0]             r_state;
    logic [acc_bw-1:0]      r_bank [col][depth];
    logic [ch_bw-1:0]       r_wr_ptr;
    logic [ch_bw-1:0]       r_num_ch;
    logic [ch_bw-1:0]       r_out_idx;
    logic [psum_bw*col-1:0] r_out_data;
    logic                   r_out_valid;
    logic                   r_err;

    logic                   w_accept;
    logic                   w_hs;
    logic                   w_last_out;
    logic [ch_bw-1:0]       w_eff_num_ch;
    logic [ch_bw-1:0]       w_cur_num_ch;
    logic [ch_bw-1:0]       w_wr_ptr_nxt;
    logic [ch_bw-1:0]       w_rd_nxt;
    logic [acc_bw-1:0]      w_sum [col];
    logic [psum_bw*col-1:0] w_first_out;
    logic [psum_bw*col-1:0] w_next_out;

    // Saturate to the signed psum range, then optional ReLU.
    function automatic logic [psum_bw-1:0] f_drain(input logic [acc_bw-1:0] v,
                                                   input logic relu);
        logic signed [acc_bw-1:0] s;
        logic signed [acc_bw-1:0] c;
        s = $signed(v);
        if (s > c_sat_hi)      c = c_sat_hi;
        else if (s < c_sat_lo) c = c_sat_lo;
        else                   c = s;
        if (relu && c[acc_bw-1]) c = '0;
        return c[psum_bw-1:0];
    endfunction

    assign in_ready  = (r_state != c_st_drain);
    assign busy      = (r_state != c_st_idle);
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign out_idx   = r_out_idx;
    assign err       = r_err;

    assign w_accept     = in_valid & in_ready;
    assign w_hs         = r_out_valid & out_ready;
    assign w_eff_num_ch = (num_ch == '0 || num_ch > c_depth) ? c_depth : num_ch;
    // In IDLE the entry count is being latched this very cycle, so the wrap
    // point must come from the live input rather than the stale register.
    assign w_cur_num_ch = (r_state == c_st_idle) ? w_eff_num_ch : r_num_ch;
    assign w_wr_ptr_nxt = (r_wr_ptr == w_cur_num_ch - 1'b1) ? '0 : r_wr_ptr + 1'b1;
    assign w_last_out   = (r_out_idx == r_num_ch - 1'b1);
    assign w_rd_nxt     = r_out_idx + 1'b1;

    for (genvar k = 0; k < col; k++) begin : g_lane
        logic signed [acc_bw-1:0] w_sext;
        assign w_sext   = acc_bw'($signed(psum_in[psum_bw*k +: psum_bw]));
        assign w_sum[k] = r_bank[k][r_wr_ptr[c_ptr_bw-1:0]] + w_sext;
        // An accept landing on entry 0 in the send_out cycle must be visible
        // in the first drained vector, so bypass the bank for that case.
        assign w_first_out[psum_bw*k +: psum_bw] =
            f_drain((w_accept && r_wr_ptr == '0) ? w_sum[k] : r_bank[k][0], relu_en);
        assign w_next_out[psum_bw*k +: psum_bw] =
            f_drain(r_bank[k][w_rd_nxt[c_ptr_bw-1:0]], relu_en);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_st_idle;
            for (int k = 0; k < col; k++) begin
                for (int e = 0; e < depth; e++) begin
                    r_bank[k][e] <= '0;
                end
            end
            r_wr_ptr    <= '0;
            r_num_ch    <= '0;
            r_out_idx   <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_accept) begin
                        r_num_ch <= w_eff_num_ch;
                        for (int k = 0; k < col; k++) begin
                            r_bank[k][r_wr_ptr[c_ptr_bw-1:0]] <= w_sum[k];
                        end
                        r_wr_ptr <= w_wr_ptr_nxt;
                        r_state  <= c_st_acc;
                    end
                end
                c_st_acc: begin
                    if (w_accept) begin
                        for (int k = 0; k < col; k++) begin
                            r_bank[k][r_wr_ptr[c_ptr_bw-1:0]] <= w_sum[k];
                        end
                        r_wr_ptr <= w_wr_ptr_nxt;
                    end
                    if (send_out) begin
                        r_state     <= c_st_drain;
                        r_out_valid <= 1'b1;
                        r_out_idx   <= '0;
                        r_out_data  <= w_first_out;
                    end
                end
                c_st_drain: begin
                    if (in_valid) r_err <= 1'b1;
                    if (w_hs) begin
                        for (int k = 0; k < col; k++) begin
                            r_bank[k][r_out_idx[c_ptr_bw-1:0]] <= '0;
                        end
                        if (w_last_out) begin
                            r_out_valid <= 1'b0;
                            r_wr_ptr    <= '0;
                            r_state     <= c_st_idle;
                        end else begin
                            r_out_idx  <= w_rd_nxt;
                            r_out_data <= w_next_out;
                        end
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sfu_acc_drain.sv
`default_nettype none
// ============================================================================
// Module   : tb_sfu_acc_drain
// Purpose  : Self-checking bench for sfu_acc_drain. A behavioural model keeps
//            the bank as plain integers and derives the whole expected drain
//            sequence at send time; scenario tasks compare the observed
//            stream against it.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sfu_acc_drain;

    localparam int PW    = 16;
    localparam int AW    = 20;
    localparam int COL   = 8;
    localparam int DEPTH = 16;
    localparam int CHW   = $clog2(DEPTH) + 1;
    localparam int VW    = PW * COL;

    logic           clk = 1'b0;
    logic           reset;
    logic [VW-1:0]  psum_in;
    logic           in_valid;
    logic           in_ready;
    logic [CHW-1:0] num_ch;
    logic           relu_en;
    logic           send_out;
    logic [VW-1:0]  out_data;
    logic           out_valid;
    logic           out_ready;
    logic [CHW-1:0] out_idx;
    logic           busy;
    logic           err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sfu_acc_drain #(
        .psum_bw (PW),
        .acc_bw  (AW),
        .col     (COL),
        .depth   (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .psum_in   (psum_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .num_ch    (num_ch),
        .relu_en   (relu_en),
        .send_out  (send_out),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .busy      (busy),
        .err       (err)
    );

    typedef struct {
        logic           v;
        logic           r;
        logic           ir;
        logic [VW-1:0]  d;
        logic [CHW-1:0] i;
    } obs_t;

    obs_t          obs_q[$];
    logic [VW-1:0] exp_q[$];

    // ---------------- behavioural model ----------------
    longint mdl_bank [COL][DEPTH];
    int     mdl_n    = DEPTH;
    int     mdl_ptr  = 0;
    bit     mdl_busy = 0;

    function automatic longint mdl_wrap(input longint v);
        longint m;
        m = longint'(1) << AW;
        v = v % m;
        if (v < 0) v += m;
        if (v >= m / 2) v -= m;
        return v;
    endfunction

    function automatic void mdl_clear();
        for (int k = 0; k < COL; k++)
            for (int e = 0; e < DEPTH; e++) mdl_bank[k][e] = 0;
        mdl_ptr  = 0;
        mdl_busy = 0;
    endfunction

    function automatic void mdl_accept(input logic [VW-1:0] vec, input logic [CHW-1:0] nch);
        if (!mdl_busy) begin
            mdl_n    = (nch == 0 || int'(nch) > DEPTH) ? DEPTH : int'(nch);
            mdl_busy = 1;
        end
        for (int k = 0; k < COL; k++) begin
            logic signed [PW-1:0] s;
            s = vec[k*PW +: PW];
            mdl_bank[k][mdl_ptr] = mdl_wrap(mdl_bank[k][mdl_ptr] + longint'(s));
        end
        mdl_ptr = (mdl_ptr + 1) % mdl_n;
    endfunction

    // Builds the full expected drain sequence and empties the model.
    function automatic void mdl_expect(input bit relu);
        exp_q.delete();
        for (int e = 0; e < mdl_n; e++) begin
            logic [VW-1:0] o;
            for (int k = 0; k < COL; k++) begin
                longint     v;
                logic [63:0] t;
                v = mdl_bank[k][e];
                if (v > 32767)  v = 32767;
                if (v < -32768) v = -32768;
                if (relu && v < 0) v = 0;
                t = v;
                o[k*PW +: PW] = t[PW-1:0];
            end
            exp_q.push_back(o);
        end
        mdl_clear();
    endfunction

    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] v;
        for (int k = 0; k < COL; k++) begin
            logic [31:0] r;
            r = $urandom();
            v[k*PW +: PW] = r[PW-1:0];
        end
        return v;
    endfunction

    // ---------------- stimulus tasks (start and end at a negedge) ----------------
    task automatic do_reset();
        reset = 1'b1; in_valid = 1'b0; send_out = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        mdl_clear();
    endtask

    task automatic push(input logic [VW-1:0] vec);
        in_valid = 1'b1;
        psum_in  = vec;
        mdl_accept(vec, num_ch);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // mode: 0 always ready, 1 ready alternating 0/1, 2 random ready.
    task automatic run_drain(input int n_hs, input int mode, input bit with_acc,
                             input logic [VW-1:0] acc_vec, input bit poke);
        int hs  = 0;
        int cyc = 0;
        obs_q.delete();
        send_out = 1'b1;
        if (with_acc) begin
            in_valid = 1'b1;
            psum_in  = acc_vec;
        end
        @(negedge clk);
        send_out = 1'b0;
        in_valid = 1'b0;
        while (hs < n_hs && cyc < 4 * n_hs + 8) begin
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (cyc % 2) == 1;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (poke && cyc == 1) begin
                in_valid = 1'b1;
                psum_in  = rand_vec();
            end else begin
                in_valid = 1'b0;
            end
            obs_q.push_back('{out_valid, out_ready, in_ready, out_data, out_idx});
            if (out_valid && out_ready) hs++;
            @(negedge clk);
            cyc++;
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b1; send_out = 1'b1; out_ready = 1'b1;
        psum_in = rand_vec(); num_ch = 1; relu_en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0; in_valid = 1'b0; send_out = 1'b0; out_ready = 1'b0;
        mdl_clear();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || err !== 1'b0 ||
            out_data !== '0 || out_idx !== '0) begin
            errors++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b busy=%b err=%b idx=%0d data=%h, want 1 0 0 0 0 0",
                     in_ready, out_valid, busy, err, out_idx, out_data);
        end
        // Inputs seen while reset was high must not have touched the bank.
        push(rand_vec());
        mdl_expect(1'b0);
        run_drain(1, 0, 1'b0, '0, 1'b0);
        checks++;
        if (obs_q.size() < 1 || obs_q[0].d !== exp_q[0]) begin
            errors++;
            $display("FAIL reset_ignores_inputs: got %h want %h",
                     obs_q.size() > 0 ? obs_q[0].d : 'x, exp_q[0]);
        end
    endtask

    task automatic test_basic();
        int lane0 [4] = '{6, 8, 10, 12};
        int k = 0;
        num_ch = 4; relu_en = 1'b0;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_in_ready_idle: got %b want 1", in_ready);
        end
        for (int a = 1; a <= 8; a++) begin
            logic [VW-1:0] v;
            v = rand_vec();
            v[PW-1:0] = PW'(a);
            push(v);
        end
        mdl_expect(1'b0);
        run_drain(4, 0, 1'b0, '0, 1'b0);
        checks++;
        if (obs_q.size() != 4) begin
            errors++;
            $display("FAIL basic_no_bubble: got %0d cycles want 4", obs_q.size());
        end
        foreach (obs_q[j]) begin
            if (obs_q[j].v && obs_q[j].r) begin
                checks++;
                if (k >= 4 || obs_q[j].d !== exp_q[k] || obs_q[j].i !== CHW'(k) ||
                    obs_q[j].d[PW-1:0] !== PW'(lane0[k])) begin
                    errors++;
                    $display("FAIL basic_out: got idx=%0d data=%h want idx=%0d data=%h",
                             obs_q[j].i, obs_q[j].d, k, k < 4 ? exp_q[k] : 'x);
                end
                k++;
            end
        end
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_idle_after: busy=%b out_valid=%b want 0 0", busy, out_valid);
        end
    endtask

    task automatic test_relu_sign();
        for (int r = 1; r >= 0; r--) begin
            logic [VW-1:0] v;
            logic [PW-1:0] want;
            v = '0;
            v[PW-1:0] = 16'hFFFB;
            num_ch = 1; relu_en = 1'(r);
            push(v);
            mdl_expect(1'(r));
            run_drain(1, 0, 1'b0, '0, 1'b0);
            want = (r == 1) ? 16'h0000 : 16'hFFFB;
            checks++;
            if (obs_q.size() < 1 || obs_q[0].d[PW-1:0] !== want || obs_q[0].d !== exp_q[0]) begin
                errors++;
                $display("FAIL relu_%0d: got lane0=%h want %h", r,
                         obs_q.size() > 0 ? obs_q[0].d[PW-1:0] : 'x, want);
            end
        end
    endtask

    task automatic test_clamp();
        logic [PW-1:0] pat [2] = '{16'h7FFF, 16'h8000};
        for (int p = 0; p < 2; p++) begin
            logic [VW-1:0] v;
            v = rand_vec();
            v[PW-1:0] = pat[p];
            num_ch = 1; relu_en = 1'b0;
            for (int a = 0; a < 3; a++) push(v);
            mdl_expect(1'b0);
            run_drain(1, 0, 1'b0, '0, 1'b0);
            checks++;
            if (obs_q.size() < 1 || obs_q[0].d[PW-1:0] !== pat[p] || obs_q[0].d !== exp_q[0]) begin
                errors++;
                $display("FAIL clamp_%h: got %h want %h", pat[p],
                         obs_q.size() > 0 ? obs_q[0].d : 'x, exp_q[0]);
            end
        end
    endtask

    task automatic test_stall();
        int k = 0;
        num_ch = 5; relu_en = 1'b1;
        for (int a = 0; a < 10; a++) push(rand_vec());
        mdl_expect(1'b1);
        run_drain(5, 1, 1'b0, '0, 1'b0);
        foreach (obs_q[j]) begin
            if (obs_q[j].v && obs_q[j].r) begin
                checks++;
                if (k >= 5 || obs_q[j].d !== exp_q[k] || obs_q[j].i !== CHW'(k)) begin
                    errors++;
                    $display("FAIL stall_out: got idx=%0d data=%h want idx=%0d data=%h",
                             obs_q[j].i, obs_q[j].d, k, k < 5 ? exp_q[k] : 'x);
                end
                k++;
            end else if (j + 1 < obs_q.size()) begin
                checks++;
                if (obs_q[j+1].v !== 1'b1 || obs_q[j+1].d !== obs_q[j].d || obs_q[j+1].i !== obs_q[j].i) begin
                    errors++;
                    $display("FAIL stall_hold: cycle %0d got v=%b idx=%0d data=%h want v=1 idx=%0d data=%h",
                             j + 1, obs_q[j+1].v, obs_q[j+1].i, obs_q[j+1].d, obs_q[j].i, obs_q[j].d);
                end
            end
        end
        checks++;
        if (k != 5) begin
            errors++;
            $display("FAIL stall_count: got %0d handshakes want 5", k);
        end
    endtask

    task automatic test_drain_err();
        int k = 0;
        num_ch = 4; relu_en = 1'b0;
        for (int a = 0; a < 6; a++) push(rand_vec());
        mdl_expect(1'b0);
        run_drain(4, 0, 1'b0, '0, 1'b1);
        checks++;
        if (obs_q.size() < 2 || obs_q[1].ir !== 1'b0) begin
            errors++;
            $display("FAIL err_in_ready: got %b want 0", obs_q.size() > 1 ? obs_q[1].ir : 1'bx);
        end
        foreach (obs_q[j]) begin
            if (obs_q[j].v && obs_q[j].r) begin
                checks++;
                if (k >= 4 || obs_q[j].d !== exp_q[k]) begin
                    errors++;
                    $display("FAIL err_data: got %h want %h", obs_q[j].d, k < 4 ? exp_q[k] : 'x);
                end
                k++;
            end
        end
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL err_set: got %b want 1", err);
        end
        push(rand_vec());
        repeat (3) @(negedge clk);
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky: got %b want 1", err);
        end
        do_reset();
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL err_reset: got %b want 0", err);
        end
    endtask

    task automatic test_reset_drain();
        int k = 0;
        num_ch = 4; relu_en = 1'b0;
        for (int a = 0; a < 4; a++) push(rand_vec());
        mdl_expect(1'b0);
        run_drain(2, 0, 1'b0, '0, 1'b0);
        reset = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_drain: out_valid=%b busy=%b want 0 0", out_valid, busy);
        end
        reset = 1'b0; out_ready = 1'b0;
        mdl_clear();
        for (int a = 0; a < 4; a++) push(rand_vec());
        mdl_expect(1'b0);
        run_drain(4, 0, 1'b0, '0, 1'b0);
        foreach (obs_q[j]) begin
            if (obs_q[j].v && obs_q[j].r) begin
                checks++;
                if (k >= 4 || obs_q[j].d !== exp_q[k]) begin
                    errors++;
                    $display("FAIL reset_fresh_acc: got %h want %h", obs_q[j].d, k < 4 ? exp_q[k] : 'x);
                end
                k++;
            end
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            int            nacc;
            int            k;
            bit            wa;
            logic [VW-1:0] v;
            send_out = 1'b1;
            @(negedge clk);
            send_out = 1'b0;
            checks++;
            if (busy !== 1'b0) begin
                errors++;
                $display("FAIL rand_idle_send: busy=%b want 0", busy);
            end
            num_ch  = CHW'($urandom_range(0, 31));
            relu_en = 1'($urandom_range(0, 1));
            nacc    = $urandom_range(1, 40);
            for (int a = 0; a < nacc; a++) begin
                push(rand_vec());
                if (a == 0) num_ch = CHW'($urandom_range(0, 31));
                if ($urandom_range(0, 3) == 0) @(negedge clk);
            end
            wa = 1'($urandom_range(0, 1));
            v  = rand_vec();
            if (wa) mdl_accept(v, num_ch);
            mdl_expect(relu_en);
            run_drain(exp_q.size(), 2, wa, v, 1'b0);
            k = 0;
            foreach (obs_q[j]) begin
                if (obs_q[j].v && obs_q[j].r) begin
                    checks++;
                    if (k >= exp_q.size() || obs_q[j].d !== exp_q[k] || obs_q[j].i !== CHW'(k)) begin
                        errors++;
                        $display("FAIL rand%0d_out: got idx=%0d data=%h want idx=%0d data=%h", it,
                                 obs_q[j].i, obs_q[j].d, k, k < exp_q.size() ? exp_q[k] : 'x);
                    end
                    k++;
                end
            end
            checks++;
            if (k != exp_q.size() || busy !== 1'b0 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL rand%0d_end: got %0d outputs busy=%b valid=%b want %0d 0 0",
                         it, k, busy, out_valid, exp_q.size());
            end
        end
    endtask

    initial begin
        reset = 1'b0; in_valid = 1'b0; send_out = 1'b0; out_ready = 1'b0;
        psum_in = '0; num_ch = '0; relu_en = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_relu_sign();
        test_clamp();
        test_stall();
        test_drain_err();
        test_reset_drain();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
        $fatal(1);
    end

endmodule
`default_nettype wire
